// File: rtl/sram_rw_ctrl_256x64_if.sv
// Request/response and macro-pin bundle for the 256x64 SRAM controller.
// slave = controller side, master = requester plus macro side.
interface sram_rw_ctrl_256x64_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              init_done;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;

    modport slave (
        input  w_valid, w_addr, w_data, r_valid, r_addr, RW0_rdata,
        output w_ready, r_ready, resp_valid, resp_data, init_done,
               RW0_addr, RW0_en, RW0_wmode, RW0_wdata
    );

    modport master (
        output w_valid, w_addr, w_data, r_valid, r_addr, RW0_rdata,
        input  w_ready, r_ready, resp_valid, resp_data, init_done,
               RW0_addr, RW0_en, RW0_wmode, RW0_wdata
    );
endinterface

// File: rtl/sram_rw_ctrl_256x64.sv
// Single-port SRAM controller: zero-fill sweep after reset, then write-priority
// arbitration of read/write channels with one-cycle read response and held data.
module sram_rw_ctrl_256x64 #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    sram_rw_ctrl_256x64_if.slave   bus
);
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_hold;

    logic w_clearing;
    logic w_run;
    logic w_wr_fire;
    logic w_rd_fire;
    logic w_resp_live;

    // Reset gates everything combinationally so the macro sees no enable and
    // a response in flight is dropped in the very cycle reset is raised.
    assign w_clearing  = (r_state == S_CLEAR) && !reset;
    assign w_run       = (r_state == S_RUN) && !reset;
    assign w_wr_fire   = w_run && bus.w_valid;
    assign w_rd_fire   = w_run && !bus.w_valid && bus.r_valid;
    assign w_resp_live = r_resp_valid && !reset;

    assign bus.init_done  = w_run;
    assign bus.w_ready    = w_run;
    assign bus.r_ready    = w_run && !bus.w_valid;
    assign bus.resp_valid = w_resp_live;
    assign bus.resp_data  = w_resp_live ? bus.RW0_rdata : r_hold;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned
        // (which would infer a latch); defaults come from reset registers, never X.
        bus.RW0_en    = 1'b0;
        bus.RW0_wmode = 1'b0;
        bus.RW0_addr  = r_clr_cnt;
        bus.RW0_wdata = '0;
        if (w_clearing) begin
            bus.RW0_en    = 1'b1;
            bus.RW0_wmode = 1'b1;
        end else if (w_wr_fire) begin
            bus.RW0_en    = 1'b1;
            bus.RW0_wmode = 1'b1;
            bus.RW0_addr  = bus.w_addr;
            bus.RW0_wdata = bus.w_data;
        end else if (w_rd_fire) begin
            bus.RW0_en    = 1'b1;
            bus.RW0_addr  = bus.r_addr;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            r_clr_cnt    <= '0;
            r_resp_valid <= 1'b0;
            r_hold       <= '0;
        end else begin
            r_resp_valid <= w_rd_fire;
            if (r_resp_valid) begin
                r_hold <= bus.RW0_rdata;
            end
            case (r_state)
                S_CLEAR: begin
                    // Counter parks at the last address; it never wraps.
                    if (r_clr_cnt == '1) begin
                        r_state <= S_RUN;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end
endmodule
